// File: rtl/psum_drain.sv
// Snapshots an MxN accumulator grid on capture and streams it out one requantized row per beat.
// Latency: row 0 is valid the cycle after capture is sampled; one row per cycle while out_ready is high.
// Backpressure: out_ready low holds the beat stable; a capture that arrives while draining is dropped and flagged.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   psum_in                 signed ACC_W grid [0:M-1][0:N-1] from the array
//   capture                 one-cycle pulse; grid valid this cycle
//   capture_ready           high while idle (a capture will be accepted)
//   capture_drop            one-cycle pulse, the cycle after a capture that was ignored
//   out_valid / out_ready   row beat handshake
//   out_row                 N requantized signed OUT_W elements
//   out_row_idx / out_last  row index of the beat / high on row M-1
//   out_sat                 any element of the beat was clamped
module psum_drain #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int M     = 16,
   parameter int N     = 16,
   parameter int SHIFT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [ACC_W-1:0] psum_in [0:M-1][0:N-1],
   input  logic                    capture,
   output logic                    capture_ready,
   output logic                    capture_drop,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_row [0:N-1],
   output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_idx,
   output logic                    out_last,
   output logic                    out_sat
);

   localparam int RW = (M > 1) ? $clog2(M) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);

   // Requantization works in ACC_W+1 bits so the rounding add cannot wrap.
   // RND is 2^(SHIFT-1), and collapses to 0 when SHIFT is 0.
   localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t                   r_state;
   logic [RW-1:0]            r_row;
   logic                     r_valid;
   logic                     r_cap_rdy;
   logic                     r_drop;
   logic signed [ACC_W-1:0]  r_buf [0:M-1][0:N-1];

   logic                     w_accept;
   logic                     w_sat_any;
   logic [OUT_W:0]           w_q [0:N-1];

   // Returns {saturated, value}.
   function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W:0] v;
      v = {x[ACC_W-1], x};
      v = (v + RND) >>> SHIFT;
      if (v > MAXV)
         requant = {1'b1, MAXV[OUT_W-1:0]};
      else if (v < MINV)
         requant = {1'b1, MINV[OUT_W-1:0]};
      else
         requant = {1'b0, v[OUT_W-1:0]};
   endfunction

   assign w_accept = capture && (r_state == S_IDLE);

   // Control FSM; all handshake-facing outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_row     <= '0;
         r_valid   <= 1'b0;
         r_cap_rdy <= 1'b1;
         r_drop    <= 1'b0;
      end else begin
         r_drop <= capture && (r_state == S_DRAIN);
         case (r_state)
            S_IDLE: begin
               if (capture) begin
                  r_state   <= S_DRAIN;
                  r_row     <= '0;
                  r_valid   <= 1'b1;
                  r_cap_rdy <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (r_row == LAST_ROW) begin
                     r_state   <= S_IDLE;
                     r_row     <= '0;
                     r_valid   <= 1'b0;
                     r_cap_rdy <= 1'b1;
                  end else begin
                     r_row <= r_row + RW'(1);
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_row     <= '0;
               r_valid   <= 1'b0;
               r_cap_rdy <= 1'b1;
            end
         endcase
      end
   end

   // Snapshot buffer: written only on an accepted capture, so drops never disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               r_buf[i][j] <= '0;
      end else if (w_accept) begin
         r_buf <= psum_in;
      end
   end

   always_comb begin
      w_sat_any = 1'b0;
      for (int j = 0; j < N; j++) begin
         w_q[j]     = requant(r_buf[r_row][j]);
         out_row[j] = w_q[j][OUT_W-1:0];
         w_sat_any  = w_sat_any | w_q[j][OUT_W];
      end
   end

   assign capture_ready = r_cap_rdy;
   assign capture_drop  = r_drop;
   assign out_valid     = r_valid;
   assign out_row_idx   = r_row;
   assign out_last      = r_valid && (r_row == LAST_ROW);
   assign out_sat       = r_valid && w_sat_any;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized bench for psum_drain with a floor-division requantization model.
// Latency: expects row 0 the cycle after capture, one row per accepted beat.
// Backpressure: drives out_ready pseudo-randomly and checks beats hold stable while stalled.
module tb_psum_drain;
   localparam int ACC_W = 32;
   localparam int OUT_W = 16;
   localparam int M     = 16;
   localparam int N     = 16;
   localparam int SHIFT = 8;

   logic                    clk;
   logic                    rst_n;
   logic signed [ACC_W-1:0] psum [0:M-1][0:N-1];
   logic                    capture;
   logic                    capture_ready;
   logic                    capture_drop;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_row [0:N-1];
   logic [3:0]              out_row_idx;
   logic                    out_last;
   logic                    out_sat;

   int n_checks = 0;
   int n_errors = 0;

   longint eg  [0:M-1][0:N-1];   // grid the DUT should be draining
   longint obs [0:M-1][0:N-1];   // values seen on each transfer
   bit     obs_sat [0:M-1];

   psum_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W), .M(M), .N(N), .SHIFT(SHIFT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .psum_in       (psum),
      .capture       (capture),
      .capture_ready (capture_ready),
      .capture_drop  (capture_drop),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_row       (out_row),
      .out_row_idx   (out_row_idx),
      .out_last      (out_last),
      .out_sat       (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Round half up: floor((x + d/2) / d) with d = 2^SHIFT.
   function automatic longint rnd(input longint x);
      longint d, n, y;
      d = longint'(1) << SHIFT;
      n = x + d / 2;
      y = n / d;
      if ((n % d != 0) && (n < 0)) y = y - 1;
      return y;
   endfunction

   function automatic longint clampv(input longint y);
      longint hi, lo;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      if (y > hi) return hi;
      if (y < lo) return lo;
      return y;
   endfunction

   function automatic longint exp_val(input int r, input int c);
      return clampv(rnd(eg[r][c]));
   endfunction

   function automatic bit exp_sat(input int r);
      bit s = 1'b0;
      for (int c = 0; c < N; c++)
         if (clampv(rnd(eg[r][c])) != rnd(eg[r][c])) s = 1'b1;
      return s;
   endfunction

   // Drive psum as already loaded, pulse capture, leave time at edge+1.
   task automatic do_capture();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            eg[i][j] = longint'(psum[i][j]);
      capture = 1'b1;
      @(posedge clk); #1;
      capture = 1'b0;
   endtask

   task automatic fill_random(input int span);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            if (span == 0) psum[i][j] = $urandom;
            else           psum[i][j] = ACC_W'($urandom_range(0, 2 * span) - span);
   endtask

   // Follow one drain. drop_beat: row on which a stray capture is issued (-1: none).
   // rst_beat: row at which reset is asserted (-1: none).
   task automatic run_drain(input int ready_pct, input int drop_beat, input int rst_beat);
      int     row = 0;
      int     cyc = 0;
      int     xfers = 0;
      bit     rdy;
      bit     exp_drop = 1'b0;
      bit     held = 1'b0;
      longint prev [0:N-1];
      int     prev_idx = 0;
      bit     prev_last = 1'b0;
      while (row < M) begin
         chk("drop", capture_drop, exp_drop);
         exp_drop = 1'b0;
         if (cyc > 400) begin
            chk("timeout_rows", row, M);
            break;
         end
         chk("valid", out_valid, 1);
         chk("cap_rdy_busy", capture_ready, 0);
         chk("row_idx", out_row_idx, row);
         chk("last", out_last, (row == M - 1));
         chk("sat", out_sat, exp_sat(row));
         for (int j = 0; j < N; j++)
            chk("data", out_row[j], exp_val(row, j));
         if (held) begin
            chk("hold_idx", out_row_idx, prev_idx);
            chk("hold_last", out_last, prev_last);
            for (int j = 0; j < N; j++)
               chk("hold_data", out_row[j], prev[j]);
         end
         for (int j = 0; j < N; j++) prev[j] = out_row[j];
         prev_idx  = out_row_idx;
         prev_last = out_last;

         if (row == rst_beat) begin
            rst_n = 1'b0;
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_cap_rdy", capture_ready, 1);
            chk("rst_idx", out_row_idx, 0);
            chk("rst_row0", out_row[0], 0);
            out_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_cap_rdy", capture_ready, 1);
            return;
         end

         rdy = ($urandom_range(0, 99) < ready_pct);
         if (row == drop_beat) begin
            rdy = 1'b1;
            fill_random(0);
            capture  = 1'b1;
            exp_drop = 1'b1;
         end
         out_ready = rdy;
         if (rdy) begin
            for (int j = 0; j < N; j++) obs[row][j] = out_row[j];
            obs_sat[row] = out_sat;
         end
         @(posedge clk); #1;
         capture = 1'b0;
         if (rdy) begin
            row++;
            xfers++;
         end
         held = !rdy;
         cyc++;
      end
      out_ready = 1'b0;
      chk("drop_end", capture_drop, exp_drop);
      chk("valid_end", out_valid, 0);
      chk("cap_rdy_end", capture_ready, 1);
      chk("xfers", xfers, M);
   endtask

   initial begin
      rst_n     = 1'b0;
      capture   = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            psum[i][j] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_cap_rdy", capture_ready, 1);
      chk("reset_drop", capture_drop, 0);
      chk("reset_idx", out_row_idx, 0);
      chk("reset_last", out_last, 0);
      chk("reset_sat", out_sat, 0);
      chk("reset_row0", out_row[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Ramp grid, full throughput: row r carries r*16+j.
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            psum[i][j] = ACC_W'((i * N + j) << 8);
      do_capture();
      run_drain(100, -1, -1);
      for (int r = 0; r < M; r += 5)
         chk("ramp", obs[r][3], r * 16 + 3);

      // Rounding and saturation corners on a small random background, 50% backpressure.
      fill_random(1 << 22);
      psum[1][0] = 383;
      psum[1][1] = 384;
      psum[1][2] = -384;
      psum[1][3] = -385;
      psum[2][5] = 32'h7FFF_FFFF;
      psum[3][7] = 32'h8000_0000;
      do_capture();
      run_drain(50, -1, -1);
      chk("rnd_383", obs[1][0], 1);
      chk("rnd_384", obs[1][1], 2);
      chk("rnd_m384", obs[1][2], -1);
      chk("rnd_m385", obs[1][3], -2);
      chk("rnd_sat", obs_sat[1], 0);
      chk("sat_pos", obs[2][5], 32767);
      chk("sat_pos_flag", obs_sat[2], 1);
      chk("sat_neg", obs[3][7], -32768);
      chk("sat_neg_flag", obs_sat[3], 1);

      // Full-range random grid with a stray capture mid-drain.
      fill_random(0);
      do_capture();
      run_drain(50, 7, -1);

      // Stray capture on the last-beat transfer cycle.
      fill_random(0);
      do_capture();
      run_drain(70, M - 1, -1);

      // Reset at beat 5, then a fresh capture drains from row 0.
      fill_random(0);
      do_capture();
      run_drain(100, -1, 5);
      fill_random(1 << 20);
      do_capture();
      run_drain(60, -1, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/psum_drain.md
# psum_drain

Output stage directly downstream of the systolic array. It snapshots the full M×N accumulator grid from `systolic_array.psum_out` on a one-cycle `capture` pulse. It then requantizes each value: arithmetic right shift with round-half-up, then signed saturation to OUT_W. Results stream out one row (N values) per beat over a valid/ready handshake, so the array can start its next tile while the previous tile drains.

## Interface
- `ACC_W`, 32: accumulator width of incoming partial sums.
- `OUT_W`, 16: width of each requantized output element (OUT_W ≤ ACC_W).
- `M`, 16: rows in the tile, equal to the number of beats per drain.
- `N`, 16: columns in the tile, equal to elements per beat.
- `SHIFT`, 8: right-shift amount applied before saturation (0 ≤ SHIFT < ACC_W).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psum_in`  in  signed ACC_W × [0:M-1][0:N-1]  array result grid.
- `capture`  in  1  one-cycle pulse; grid valid this cycle.
- `capture_ready`  out  1  high when a capture will be accepted (IDLE).
- `capture_drop`  out  1  one-cycle pulse when `capture` arrives while not ready.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_row`  out  signed OUT_W × [0:N-1]  requantized row.
- `out_row_idx`  out  $clog2(M)  row index of the current beat, with a minimum width of 1.
- `out_last`  out  1  high with the beat for row M-1.
- `out_sat`  out  1  high if any element of the current beat saturated.

## Operation
- FSM states:
  - IDLE: `capture_ready`=1 and `out_valid`=0.
  - DRAIN: `out_valid`=1 and `capture_ready`=0.
- IDLE, `capture`=1: latch all M×N `psum_in` into the snapshot buffer, set row_idx=0, go to DRAIN.
- DRAIN, `out_valid`&&`out_ready` (a beat transfers):
  - If row_idx<M-1: row_idx increments.
  - If row_idx=M-1: return to IDLE.
- DRAIN, `out_ready`=0: hold. `out_row`, `out_row_idx`, `out_last` and `out_sat` stay stable; valid never drops before the transfer.
- `capture` in DRAIN: ignored; the buffer is not modified; `capture_drop` pulses the following cycle.
- Capture on the same cycle as the last-beat transfer: still DRAIN, so it is dropped. Back-to-back capture requires one IDLE cycle.
- Requantization per element x, computed in ACC_W+1 bits:
  - SHIFT>0: y = (x + 2^(SHIFT-1)) >>> SHIFT.
  - SHIFT=0: y = x.
  - Clamp y to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. `out_sat` is the OR of clamp events across the row.
  - The rounding add must not wrap: x = 2^(ACC_W-1)-1 rounds positive and then saturates.
- `out_row` is combinational from the buffer row selected by row_idx. The buffer and row_idx are registered, so outputs are glitch-free relative to the handshake edge.
- Reset mid-drain: returns to IDLE immediately and discards all remaining beats.

## Timing
- Reset values:
  - state=IDLE, row_idx=0, buffer all 0.
  - `out_valid`=0, `capture_ready`=1, `capture_drop`=0.
  - `out_row`=0, `out_row_idx`=0, `out_last`=0, `out_sat`=0.
- Capture latency: `capture` sampled at edge k; `out_valid`=1 from the cycle after edge k, showing row 0.
- Throughput: with `out_ready` held high, one row per cycle. Drain takes M cycles; `capture_ready` rises the cycle after the row M-1 transfer edge.
- `capture_ready` is registered-state derived and does not depend combinationally on `capture` or `out_ready`.
- `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- Reset, then load grid psum[i][j]=(i*N+j)<<8 with SHIFT=8, OUT_W=16; pulse capture, `out_ready`=1.
  - 16 consecutive beats; row r carries r*16+j.
  - `out_last` high only on beat 15.
  - `capture_ready` returns 1 one cycle later.
- Rounding with SHIFT=8 (one element per case):
  - psum=383 → 1.
  - psum=384 → 2.
  - psum=-384 → -1.
  - psum=-385 → -2.
  - `out_sat`=0 in all four cases.
- Saturation: psum=0x7FFFFFFF → 32767 with `out_sat`=1; psum=0x80000000 → -32768 with `out_sat`=1; the other elements in those rows are unaffected.
- Backpressure: toggle `out_ready` pseudo-randomly (~50%).
  - Data, `out_row_idx` and `out_last` stay stable while valid && !ready.
  - Exactly 16 transfers occur, in order, with no duplicates.
- Capture during DRAIN (including the last-beat cycle): `capture_drop` pulses once; remaining beats still carry the original grid; the new grid is never emitted.
- Assert `rst_n`=0 at beat 5: the next cycle shows `out_valid`=0 and `capture_ready`=1; a new capture after reset drains from row 0 with fresh data.
